// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_t : controller state encoding (IDLE, ITER, DONE)
//   DIV0_Q_BIT  : fill bit for the quotient reported on divide-by-zero
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Quotient on divide-by-zero is all ones; replicated to WIDTH at the use site.
  localparam bit DIV0_Q_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
// Ports:
//   r      : current partial remainder (low WIDTH bits; bit WIDTH is always 0 between steps)
//   q_msb  : next dividend bit shifted into the remainder
//   d      : divisor
//   r_next : partial remainder after this step
//   q_bit  : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] rs;
  logic [WIDTH:0] diff;
  logic           borrow;

  always_comb begin
    rs     = {r, q_msb};
    diff   = rs - {1'b0, d};
    borrow = diff[WIDTH];
    q_bit  = ~borrow;
    // When the subtract succeeds the result is below D; when it borrows, Rs
    // itself is below D. Either way the top bit is zero, so WIDTH bits carry R.
    r_next = borrow ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned restoring divider controller, one quotient bit per clock.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start               : request, accepted when busy=0 (IDLE or DONE)
//   dividend, divisor   : operands, sampled with an accepted start
//   busy                : high while iterating
//   done                : one-cycle pulse when results become valid
//   quotient, remainder : results, held until the next completion
//   div_by_zero         : set with done when divisor was zero
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state, state_nx;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;
  logic             accept;
  logic             dv_zero;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q_msb  (q_sh[WIDTH-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign accept  = start && (state != ITER);
  assign dv_zero = (divisor == '0);
  assign busy    = (state == ITER);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nx = dv_zero ? DONE : ITER;
        else       state_nx = IDLE;
      end
      ITER:    if (cnt == '0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sh        <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (dv_zero) begin
        quotient    <= {WIDTH{DIV0_Q_BIT}};
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        q_sh  <= dividend;
        d_reg <= divisor;
        r_reg <= '0;
        cnt   <= CNT_W'(WIDTH - 1);
      end
    end else if (state == ITER) begin
      r_reg <= r_next;
      q_sh  <= {q_sh[WIDTH-2:0], q_bit};
      if (cnt == '0) begin
        quotient    <= {q_sh[WIDTH-2:0], q_bit};
        remainder   <= r_next;
        div_by_zero <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;
  logic         prev_z = 1'b0;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge; start is seen by the following rising edge (edge 0).
  task automatic launch(input logic [W-1:0] dd, input logic [W-1:0] dv);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
  endtask

  // Ends at the negedge inside the done cycle so a following launch is back-to-back.
  task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input int ign_at);
    launch(dd, dv);
    if (dv != '0) begin
      for (int k = 1; k <= W; k++) begin
        @(negedge clk);
        check("busy_iter", {31'd0, busy}, 32'd1);
        check("done_iter", {31'd0, done}, 32'd0);
        if (k == 16) begin
          check("q_held_iter", quotient, prev_q);
          check("r_held_iter", remainder, prev_r);
        end
        if (k == ign_at) begin
          start    = 1'b1;
          dividend = 32'd50;
          divisor  = 32'd5;
          @(posedge clk);
          #1;
          start = 1'b0;
        end
      end
    end
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
    prev_q = eq;
    prev_r = er;
    prev_z = ez;
  endtask

  task automatic idle_gap();
    @(negedge clk);
    check("done_drop", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("q_hold", quotient, prev_q);
    check("r_hold", remainder, prev_r);
    check("z_hold", {31'd0, div_by_zero}, {31'd0, prev_z});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
    idle_gap();
    run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    idle_gap();
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
    idle_gap();

    run_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    idle_gap();
    @(negedge clk);
    check("busy_div0_after", {31'd0, busy}, 32'd0);

    run_div(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 10);
    idle_gap();
    idle_gap();

    run_div(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 0);
    idle_gap();
    run_div(32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 0);
    idle_gap();

    // back-to-back: second start held in the first op's done cycle
    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
    run_div(32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 0);
    idle_gap();

    // reset in the middle of iterating
    launch(32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    check("busy_pre_rst", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    check("abort_z", {31'd0, div_by_zero}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    prev_q = '0;
    prev_r = '0;
    prev_z = 1'b0;
    idle_gap();
    run_div(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 0);
    idle_gap();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
